// File: rtl/adder.sv
// Registered two-operand integer adder with carry-lookahead core.
// The sum and its flags are captured one clock after a valid strobe. The core is
// built from 4-bit CLA groups plus a group-level lookahead carry unit.
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  localparam int unsigned NG = WIDTH / 4;

  logic [WIDTH-1:0] g;   // bit generate
  logic [WIDTH-1:0] p;   // bit propagate
  logic [WIDTH-1:0] c;   // carry into each bit
  logic [WIDTH-1:0] s;   // combinational sum
  logic [NG-1:0]    gg;  // group generate
  logic [NG-1:0]    gp;  // group propagate
  logic [NG:0]      gc;  // carry into each group; gc[NG] is the final carry out

  logic s_carry;
  logic s_overflow;
  logic s_zero;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit CLA groups: group G/P and the in-group carries from the group carry-in.
  for (genvar k = 0; k < NG; k++) begin : gen_grp
    logic [3:0] gk;
    logic [3:0] pk;
    logic       ck;

    assign gk = g[4*k +: 4];
    assign pk = p[4*k +: 4];
    assign ck = gc[k];

    assign gg[k] = gk[3]
                 | (pk[3] & gk[2])
                 | (pk[3] & pk[2] & gk[1])
                 | (pk[3] & pk[2] & pk[1] & gk[0]);
    assign gp[k] = &pk;

    assign c[4*k]     = ck;
    assign c[4*k + 1] = gk[0] | (pk[0] & ck);
    assign c[4*k + 2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & ck);
    assign c[4*k + 3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0])
                      | (pk[2] & pk[1] & pk[0] & ck);
  end

  // Group lookahead: every group carry is a flat sum of products from cin, so no
  // carry ripples from one group to the next.
  assign gc[0] = cin;
  for (genvar k = 0; k < NG; k++) begin : gen_la
    logic [k+1:0] t;
    for (genvar j = 0; j <= k; j++) begin : gen_t
      if (j == k) begin : gen_last
        assign t[j] = gg[j];
      end else begin : gen_mid
        assign t[j] = gg[j] & (&gp[k:j+1]);
      end
    end
    assign t[k+1]  = cin & (&gp[k:0]);
    assign gc[k+1] = |t;
  end

  assign s          = p ^ c;
  assign s_carry    = gc[NG];
  assign s_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  assign s_zero     = ~|s;

  // Output registers: the result and its flags load together on a valid strobe and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= s;
        carry_out <= s_carry;
        overflow  <= s_overflow;
        zero      <= s_zero;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed test-plan vectors, a mid-stream reset,
// and a randomized run compared against a plain-arithmetic reference model.
module tb_adder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        out_valid;

  int total;
  int bad;

  // Reference model state: what the outputs should show right now.
  logic [31:0] m_sum;
  logic        m_cout;
  logic        m_ovf;
  logic        m_zero;
  logic        m_valid;

  adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic check_model(input string tag);
    check({tag, "_sum"},   64'(sum),       64'(m_sum));
    check({tag, "_cout"},  64'(carry_out), 64'(m_cout));
    check({tag, "_ovf"},   64'(overflow),  64'(m_ovf));
    check({tag, "_zero"},  64'(zero),      64'(m_zero));
    check({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
  endtask

  // Drive one cycle of stimulus, let the edge happen, update the model, then compare.
  task automatic step(input logic v, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tc, input string tag);
    logic [32:0] full;
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    @(posedge clk);
    #1;
    if (v) begin
      full   = {1'b0, ta} + {1'b0, tb} + {32'b0, tc};
      m_sum  = full[31:0];
      m_cout = full[32];
      m_ovf  = (ta[31] == tb[31]) && (full[31] != ta[31]);
      m_zero = (full[31:0] == 32'h0);
    end
    m_valid = v;
    check_model(tag);
  endtask

  task automatic model_reset();
    m_sum   = '0;
    m_cout  = 1'b0;
    m_ovf   = 1'b0;
    m_zero  = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    model_reset();

    // Reset state before any clock edge.
    #1;
    check_model("reset0");
    @(posedge clk);
    #1;
    check_model("reset1");
    reset = 1'b0;

    // Test-plan vectors with literal expectations as well as the model.
    step(1'b1, 32'hA5A5A5A5, 32'h12345678, 1'b0, "tp1");
    check("tp1_lit_sum", 64'(sum), 64'h00000000B7D9FC1D);
    check("tp1_lit_flags", 64'({carry_out, overflow, zero, out_valid}), 64'(4'b0001));

    step(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, "tp2");
    check("tp2_lit", 64'({carry_out, overflow, zero, sum}), {29'b0, 3'b101, 32'h0});

    step(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, "tp3a");
    check("tp3a_lit", 64'({carry_out, overflow, zero, sum}), {29'b0, 3'b010, 32'h80000000});

    step(1'b1, 32'h80000000, 32'h80000000, 1'b0, "tp3b");
    check("tp3b_lit", 64'({carry_out, overflow, zero, sum}), {29'b0, 3'b111, 32'h0});

    step(1'b1, 32'h0000000F, 32'h000000F0, 1'b1, "tp4");
    check("tp4_lit", 64'({carry_out, sum}), {31'b0, 1'b0, 32'h00000100});

    // Back-to-back stream then idle: sum must hold while out_valid drops.
    step(1'b1, 32'd1, 32'd2, 1'b0, "bb1");
    check("bb1_lit", 64'(sum), 64'd3);
    step(1'b1, 32'd3, 32'd4, 1'b0, "bb2");
    check("bb2_lit", 64'(sum), 64'd7);
    step(1'b1, 32'd5, 32'd6, 1'b0, "bb3");
    check("bb3_lit", 64'(sum), 64'h0B);
    step(1'b0, 32'hDEADBEEF, 32'h12345678, 1'b1, "idle1");
    check("idle1_lit", 64'({out_valid, sum}), {31'b0, 1'b0, 32'h0000000B});
    step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "idle2");

    // Mid-stream asynchronous reset, asserted between edges.
    step(1'b1, 32'h12345678, 32'h11111111, 1'b0, "pre_rst");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    check_model("rst_hold");
    reset = 1'b0;
    step(1'b0, 32'h00000001, 32'h00000001, 1'b0, "post_rst");
    step(1'b0, 32'h00000002, 32'h00000002, 1'b0, "post_rst2");

    // Randomized run with occasional idle cycles.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
